// File: rtl/gcd_binary_hs.sv
// Binary (Stein) GCD engine with valid/ready operand and result handshakes.
// Reports the number of CALC cycles spent on each result, saturating at 2**CNT_W-1.
module gcd_binary_hs #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] xi,
  input  logic [WIDTH-1:0] yi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] xo,
  output logic [CNT_W-1:0] iters,
  output logic             busy
);
  // state  | meaning
  // IDLE   | waiting for an operand pair, in_ready high
  // CALC   | one Stein reduction step per cycle
  // DONE   | result presented, held until out_ready
  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, a_nxt, b_nxt, xo_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, iters_nxt;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    k_nxt     = k;
    cnt_nxt   = cnt;
    xo_nxt    = xo;
    iters_nxt = iters;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          a_nxt   = xi;
          b_nxt   = yi;
          k_nxt   = '0;
          cnt_nxt = '0;
          if (xi == '0 || yi == '0) begin
            xo_nxt    = xi | yi;
            iters_nxt = '0;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_nxt = cnt_inc;
        if (a == b) begin
          xo_nxt    = a << k;
          iters_nxt = cnt_inc;
          state_nxt = S_DONE;
        end else if (!a[0] && !b[0]) begin
          a_nxt = a >> 1;
          b_nxt = b >> 1;
          k_nxt = k + 1'b1;
        end else if (!a[0]) begin
          a_nxt = a >> 1;
        end else if (!b[0]) begin
          b_nxt = b >> 1;
        end else if (a > b) begin
          // both odd here, so the difference is even and the shift is exact
          a_nxt = (a - b) >> 1;
        end else begin
          b_nxt = (b - a) >> 1;
        end
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a     <= '0;
      b     <= '0;
      k     <= '0;
      cnt   <= '0;
      xo    <= '0;
      iters <= '0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
      k     <= k_nxt;
      cnt   <= cnt_nxt;
      xo    <= xo_nxt;
      iters <= iters_nxt;
    end
  end

endmodule
